token_precision_analyzer: RTL
=============================

TOKEN_PRECISION_ANALYZER -- requirements
Module: token_precision_analyzer

Interface
REQ-001: Parameter A_ROWS, default 8, rows of attention matrix (queries).
REQ-002: Parameter NUM_COLS, default 8, columns of attention matrix (tokens).
REQ-003: Parameter WIDTH, default 16, attention element width, unsigned Q1.15.
REQ-004: Parameter THR_HI, default 16'h2000, column-max threshold for FP16.
REQ-005: Parameter THR_LO, default 16'h0800, column-max threshold for INT8.
REQ-006: clk  input  1  clock, all state updates on rising edge.
REQ-007: rst_n  input  1  reset, asynchronous, active-low.
REQ-008: in_valid  input  1  attention element beat valid.
REQ-009: in_data  input  WIDTH  attention element, column-major order (row 0..A_ROWS-1 of col 0, then col 1, ...).
REQ-010: in_ready  output  1  block accepts a beat; transfer occurs when in_valid && in_ready.
REQ-011: a_mem  output  [A_ROWS][NUM_COLS] x WIDTH  buffered attention matrix for the A*V multiplier.
REQ-012: precision_sel  output  [NUM_COLS] x 2  per-column precision code: 00 INT4, 01 INT8, 10 FP16.
REQ-013: av_start  output  1  one-cycle start pulse to the A*V multiplier.
REQ-014: av_done  input  1  completion pulse from the A*V multiplier.
REQ-015: busy  output  1  high in any state except IDLE.

Function
REQ-016: FSM states IDLE, LOAD, START, WAIT_DONE; no other reachable states.
REQ-017: in_ready = 1 in IDLE and LOAD, 0 in START and WAIT_DONE; beats with in_ready low are ignored, not buffered.
REQ-018: IDLE -> LOAD on an accepted beat; that beat is element (row 0, col 0).
REQ-019: Row counter 0..A_ROWS-1 and column counter 0..NUM_COLS-1 advance per accepted beat; row wraps to 0 and column increments after row A_ROWS-1.
REQ-020: Each accepted beat is written to a_mem[row][col] at the accepting edge.
REQ-021: Running column max: row-0 beat loads col_max = in_data; subsequent beats set col_max = max(col_max, in_data), unsigned compare.
REQ-022: On the row A_ROWS-1 beat of column c, m = max(col_max, in_data); precision_sel[c] is written at that edge: 10 if m >= THR_HI, else 01 if m >= THR_LO, else 00.
REQ-023: Equality with a threshold selects the higher precision.
REQ-024: Final beat (row A_ROWS-1, col NUM_COLS-1) moves LOAD -> START; counters return to 0.
REQ-025: av_start = 1 exactly while in START (one cycle); START -> WAIT_DONE unconditionally.
REQ-026: Latency: av_start high in the cycle immediately after the final beat is accepted; precision_sel and a_mem are complete in that cycle.
REQ-027: WAIT_DONE -> IDLE on av_done = 1; av_done in any other state is ignored.
REQ-028: a_mem and precision_sel are held unchanged from START until the next frame's writes; no write occurs outside accepted beats.
REQ-029: in_valid low mid-frame stalls counters and col_max; no timeout.

Reset
REQ-030: On rst_n = 0 (any time, including mid-frame or WAIT_DONE): state IDLE, counters 0, col_max 0, all precision_sel 00, all a_mem 0, av_start 0, busy 0; in_ready = 1 after reset release.
REQ-031: A partial frame interrupted by reset is discarded; the next accepted beat is row 0, col 0.

Verification
REQ-032: Frame with all elements 16'h0100, in_valid continuous -> all precision_sel = 00, av_start pulse exactly A_ROWS*NUM_COLS cycles after first beat accepted, busy high until av_done.
REQ-033: Col 0 max 16'h2000, col 1 max 16'h1FFF, col 2 max 16'h0800, col 3 max 16'h07FF, rest 0 -> precision_sel = 10, 01, 01, 00, 00...; max placed in row 0, middle row and row A_ROWS-1 in separate runs with identical result.
REQ-034: Random in_valid gaps with random data -> a_mem equals reference column-major matrix; precision_sel matches model; in_data changing while in_valid low has no effect.
REQ-035: After av_start, in_valid held high through WAIT_DONE -> in_ready 0, no a_mem change; av_done after 50 cycles -> IDLE, next beat writes a_mem[0][0].
REQ-036: rst_n asserted after 20 beats -> all outputs cleared immediately (asynchronous); new full frame afterwards produces correct a_mem, precision_sel and a single av_start.
REQ-037: av_done pulsed in IDLE and LOAD -> no state change, no av_start.

Source files
------------

// File: rtl/token_precision_analyzer.sv
// token_precision_analyzer
//   Buffers one attention matrix (A_ROWS x NUM_COLS), streamed in column-major
//   order, and picks a per-column precision code from the column maximum.
//   Once the whole matrix is stored, it pulses av_start to the A*V multiplier.
//   It then waits for av_done before it accepts the next frame.
//
// Ports
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   in_valid       attention element beat valid
//   in_data        attention element, unsigned Q1.15, column-major
//   in_ready       beat accepted when in_valid && in_ready (IDLE/LOAD only)
//   a_mem          buffered matrix, a_mem[row][col]
//   precision_sel  per-column code: 00 INT4, 01 INT8, 10 FP16
//   av_start       one-cycle start pulse to the A*V multiplier
//   av_done        completion pulse from the A*V multiplier
//   busy           high whenever the controller is not idle
module token_precision_analyzer #(
  parameter int               A_ROWS   = 8,
  parameter int               NUM_COLS = 8,
  parameter int               WIDTH    = 16,
  parameter logic [WIDTH-1:0] THR_HI   = 16'h2000,
  parameter logic [WIDTH-1:0] THR_LO   = 16'h0800
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic                                        in_valid,
  input  logic [WIDTH-1:0]                            in_data,
  output logic                                        in_ready,
  output logic [A_ROWS-1:0][NUM_COLS-1:0][WIDTH-1:0]  a_mem,
  output logic [NUM_COLS-1:0][1:0]                    precision_sel,
  output logic                                        av_start,
  input  logic                                        av_done,
  output logic                                        busy
);

  localparam int ROW_W = (A_ROWS   > 1) ? $clog2(A_ROWS)   : 1;
  localparam int COL_W = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(A_ROWS - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(NUM_COLS - 1);

  localparam logic [1:0] PREC_INT4 = 2'b00;
  localparam logic [1:0] PREC_INT8 = 2'b01;
  localparam logic [1:0] PREC_FP16 = 2'b10;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    LOAD      = 2'b01,
    START     = 2'b10,
    WAIT_DONE = 2'b11
  } state_t;

  // Precision from a column maximum; hitting a threshold exactly selects the
  // higher precision.
  function automatic logic [1:0] prec_code(input logic [WIDTH-1:0] m);
    logic [1:0] code;
    if (m >= THR_HI) begin
      code = PREC_FP16;
    end else if (m >= THR_LO) begin
      code = PREC_INT8;
    end else begin
      code = PREC_INT4;
    end
    return code;
  endfunction

  state_t             state_r;
  state_t             state_nx_s;
  logic [ROW_W-1:0]   row_r;
  logic [COL_W-1:0]   col_r;
  logic [WIDTH-1:0]   col_max_r;
  logic [WIDTH-1:0]   beat_max_s;
  logic               accept_s;
  logic               last_row_s;
  logic               last_col_s;

  assign accept_s   = in_valid && in_ready;
  assign last_row_s = (row_r == ROW_LAST);
  assign last_col_s = (col_r == COL_LAST);

  // Running column max including the current beat; row 0 restarts the max.
  always_comb begin
    beat_max_s = col_max_r;
    if (row_r == {ROW_W{1'b0}}) begin
      beat_max_s = in_data;
    end else if (in_data > col_max_r) begin
      beat_max_s = in_data;
    end else begin
      beat_max_s = col_max_r;
    end
  end

  // Next-state decode for the frame controller.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE, LOAD: begin
        if (accept_s && last_row_s && last_col_s) begin
          state_nx_s = START;
        end else if (accept_s) begin
          state_nx_s = LOAD;
        end else begin
          state_nx_s = state_r;
        end
      end
      START: begin
        state_nx_s = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (av_done) begin
          state_nx_s = IDLE;
        end else begin
          state_nx_s = WAIT_DONE;
        end
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // Controller state and its registered outputs, decoded from the next state
  // so that they line up with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      in_ready <= 1'b1;
      av_start <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state_r  <= state_nx_s;
      in_ready <= (state_nx_s == IDLE) || (state_nx_s == LOAD);
      av_start <= (state_nx_s == START);
      busy     <= (state_nx_s != IDLE);
    end
  end

  // Beat datapath: store the element, track the column max, and commit the
  // column's precision on its last row. Counters only move on accepted beats,
  // so a stalled in_valid freezes everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_r         <= {ROW_W{1'b0}};
      col_r         <= {COL_W{1'b0}};
      col_max_r     <= {WIDTH{1'b0}};
      a_mem         <= {(A_ROWS*NUM_COLS*WIDTH){1'b0}};
      precision_sel <= {(NUM_COLS*2){1'b0}};
    end else if (accept_s) begin
      a_mem[row_r][col_r] <= in_data;
      col_max_r           <= beat_max_s;
      if (last_row_s) begin
        precision_sel[col_r] <= prec_code(beat_max_s);
        row_r                <= {ROW_W{1'b0}};
        if (last_col_s) begin
          col_r <= {COL_W{1'b0}};
        end else begin
          col_r <= col_r + 1'b1;
        end
      end else begin
        row_r <= row_r + 1'b1;
      end
    end else begin
      row_r     <= row_r;
      col_r     <= col_r;
      col_max_r <= col_max_r;
    end
  end

endmodule
